tl_clint_arbiter: RTL

- N-to-1 TileLink-UH arbiter that sits directly upstream of the CLINT slave port.
- Merges the A channels of several hart-side masters onto one registered A output using round-robin arbitration.
- Extends the source ID with the master index, and routes the CLINT's D responses back to the originating master by decoding that index.

---
 rtl/clint_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 26 ++
 rtl/tl_clint_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// Shared TileLink constants and the A-beat payload for the CLINT arbiter.
package clint_pkg;

  localparam int unsigned OPW   = 3;
  localparam int unsigned PRMW  = 3;
  localparam int unsigned DPRMW = 2;
  localparam int unsigned SZW   = 4;
  localparam int unsigned ADW   = 16;
  localparam int unsigned MKW   = 4;
  localparam int unsigned DW    = 32;

  localparam logic [OPW-1:0] TL_PUT_FULL        = 3'd0;
  localparam logic [OPW-1:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [OPW-1:0] TL_ARITHMETIC      = 3'd2;
  localparam logic [OPW-1:0] TL_LOGICAL         = 3'd3;
  localparam logic [OPW-1:0] TL_GET             = 3'd4;
  localparam logic [OPW-1:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [OPW-1:0] TL_ACCESS_ACK_DATA = 3'd1;

  // Largest size the 32-bit CLINT data path accepts in one beat.
  localparam logic [SZW-1:0] TL_MAX_SIZE = 4'd2;

  // A-channel payload without the source, whose width depends on the arbiter.
  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [PRMW-1:0] param;
    logic [SZW-1:0]  size;
    logic [ADW-1:0]  address;
    logic [MKW-1:0]  mask;
    logic [DW-1:0]   data;
    logic            corrupt;
  } a_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set bit of valid at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_valid
);

  int unsigned cand;

  // Scan offsets high to low so the closest requester to ptr wins last.
  always_comb begin
    grant     = '0;
    any_valid = |valid;
    cand      = 0;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      cand = 32'(ptr) + 32'(off);
      if (cand >= N) cand = cand - N;
      if (valid[cand]) grant = IW'(cand);
    end
  end

endmodule

// File: rtl/tl_clint_arbiter.sv
// N-to-1 TileLink-UH arbiter in front of the CLINT: round-robin A merge with a
// one-entry A output register, and zero-latency D routing on the source index.
// Optional: CLINT_ARB_DENY_BURST_EN answers a_size>2 requests locally with a
// denied D beat instead of forwarding them.
module tl_clint_arbiter
  import clint_pkg::*;
#(
  parameter  int unsigned NMASTERS = 2,
  parameter  int unsigned TL_RS    = 4,
  localparam int unsigned IDXW     = $clog2(NMASTERS),
  localparam int unsigned SW       = TL_RS + IDXW
) (
  input  logic                      arb_clock_i,
  input  logic                      arb_reset_i,
  input  logic [NMASTERS*OPW-1:0]   m_a_opcode,
  input  logic [NMASTERS*PRMW-1:0]  m_a_param,
  input  logic [NMASTERS*SZW-1:0]   m_a_size,
  input  logic [NMASTERS*TL_RS-1:0] m_a_source,
  input  logic [NMASTERS*ADW-1:0]   m_a_address,
  input  logic [NMASTERS*MKW-1:0]   m_a_mask,
  input  logic [NMASTERS*DW-1:0]    m_a_data,
  input  logic [NMASTERS-1:0]       m_a_corrupt,
  input  logic [NMASTERS-1:0]       m_a_valid,
  output logic [NMASTERS-1:0]       m_a_ready,
  output logic [NMASTERS*OPW-1:0]   m_d_opcode,
  output logic [NMASTERS*DPRMW-1:0] m_d_param,
  output logic [NMASTERS*SZW-1:0]   m_d_size,
  output logic [NMASTERS*TL_RS-1:0] m_d_source,
  output logic [NMASTERS-1:0]       m_d_denied,
  output logic [NMASTERS*DW-1:0]    m_d_data,
  output logic [NMASTERS-1:0]       m_d_corrupt,
  output logic [NMASTERS-1:0]       m_d_valid,
  input  logic [NMASTERS-1:0]       m_d_ready,
  output logic [OPW-1:0]            s_a_opcode,
  output logic [PRMW-1:0]           s_a_param,
  output logic [SZW-1:0]            s_a_size,
  output logic [SW-1:0]             s_a_source,
  output logic [ADW-1:0]            s_a_address,
  output logic [MKW-1:0]            s_a_mask,
  output logic [DW-1:0]             s_a_data,
  output logic                      s_a_corrupt,
  output logic                      s_a_valid,
  input  logic                      s_a_ready,
  input  logic [OPW-1:0]            s_d_opcode,
  input  logic [DPRMW-1:0]          s_d_param,
  input  logic [SZW-1:0]            s_d_size,
  input  logic [SW-1:0]             s_d_source,
  input  logic                      s_d_denied,
  input  logic [DW-1:0]             s_d_data,
  input  logic                      s_d_corrupt,
  input  logic                      s_d_valid,
  output logic                      s_d_ready
);

  logic                load_en, any_valid, hs, hs_fwd;
  logic [NMASTERS-1:0] req;
  logic [IDXW-1:0]     grant, rr_ptr, ptr_next, d_idx;
  logic                d_legal;
  a_beat_t             a_q, a_sel;
  logic [SW-1:0]       src_q, src_sel;
  logic                a_valid_q;
  int unsigned         g;

  assign load_en = ~a_valid_q | s_a_ready;
  assign hs      = load_en & any_valid;

`ifdef CLINT_ARB_DENY_BURST_EN
  logic                lr_valid;
  logic [IDXW-1:0]     lr_idx;
  logic [TL_RS-1:0]    lr_src;
  logic [SZW-1:0]      lr_size;
  logic [OPW-1:0]      lr_op;
  logic [OPW-1:0]      lr_ack_op;
  logic [NMASTERS-1:0] burst;
  logic                hs_deny;

  // Oversized requests compete only while the local-response slot is free.
  always_comb begin
    burst = '0;
    for (int i = 0; i < int'(NMASTERS); i++)
      burst[i] = m_a_size[SZW*i +: SZW] > TL_MAX_SIZE;
    req = m_a_valid & ~(burst & {NMASTERS{lr_valid}});
  end

  assign hs_deny   = hs & burst[grant];
  assign hs_fwd    = hs & ~burst[grant];
  assign lr_ack_op = (lr_op == TL_PUT_FULL || lr_op == TL_PUT_PARTIAL) ?
                     TL_ACCESS_ACK : TL_ACCESS_ACK_DATA;

  // Local-response slot: filled by a denied grant, drained by that master's d_ready.
  always_ff @(posedge arb_clock_i or negedge arb_reset_i) begin
    if (!arb_reset_i) begin
      lr_valid <= 1'b0;
      lr_idx   <= '0;
      lr_src   <= '0;
      lr_size  <= '0;
      lr_op    <= '0;
    end else if (hs_deny) begin
      lr_valid <= 1'b1;
      lr_idx   <= grant;
      lr_src   <= m_a_source[TL_RS*g +: TL_RS];
      lr_size  <= m_a_size[SZW*g +: SZW];
      lr_op    <= m_a_opcode[OPW*g +: OPW];
    end else if (lr_valid && m_d_ready[lr_idx]) begin
      lr_valid <= 1'b0;
    end
  end
`else
  assign req    = m_a_valid;
  assign hs_fwd = hs;
`endif

  rr_arbiter #(.N(NMASTERS)) u_rr (
    .valid     (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign ptr_next = (32'(grant) == NMASTERS - 1) ? '0 : grant + IDXW'(1);

  // Pick the granted master's fields and drive its ready.
  always_comb begin
    g               = 32'(grant);
    a_sel.opcode    = m_a_opcode[OPW*g +: OPW];
    a_sel.param     = m_a_param[PRMW*g +: PRMW];
    a_sel.size      = m_a_size[SZW*g +: SZW];
    a_sel.address   = m_a_address[ADW*g +: ADW];
    a_sel.mask      = m_a_mask[MKW*g +: MKW];
    a_sel.data      = m_a_data[DW*g +: DW];
    a_sel.corrupt   = m_a_corrupt[g];
    src_sel         = {grant, m_a_source[TL_RS*g +: TL_RS]};
    m_a_ready       = '0;
    for (int i = 0; i < int'(NMASTERS); i++)
      m_a_ready[i] = load_en & any_valid & (grant == IDXW'(i));
  end

  // Single-entry A output register and round-robin pointer.
  always_ff @(posedge arb_clock_i or negedge arb_reset_i) begin
    if (!arb_reset_i) begin
      a_valid_q <= 1'b0;
      a_q       <= '0;
      src_q     <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      a_valid_q <= hs_fwd;
      if (hs_fwd) begin
        a_q   <= a_sel;
        src_q <= src_sel;
      end
      if (hs) rr_ptr <= ptr_next;
    end
  end

  assign s_a_opcode  = a_q.opcode;
  assign s_a_param   = a_q.param;
  assign s_a_size    = a_q.size;
  assign s_a_address = a_q.address;
  assign s_a_mask    = a_q.mask;
  assign s_a_data    = a_q.data;
  assign s_a_corrupt = a_q.corrupt;
  assign s_a_source  = src_q;
  assign s_a_valid   = a_valid_q;

  assign d_idx   = s_d_source[SW-1 -: IDXW];
  assign d_legal = 32'(d_idx) < NMASTERS;

  // Fan the CLINT D beat out to the master named by the source index.
  always_comb begin
    m_d_opcode  = '0;
    m_d_param   = '0;
    m_d_size    = '0;
    m_d_source  = '0;
    m_d_denied  = '0;
    m_d_data    = '0;
    m_d_corrupt = '0;
    m_d_valid   = '0;
    s_d_ready   = 1'b1;
    for (int i = 0; i < int'(NMASTERS); i++) begin
      m_d_opcode[OPW*i +: OPW]     = s_d_opcode;
      m_d_param[DPRMW*i +: DPRMW]  = s_d_param;
      m_d_size[SZW*i +: SZW]       = s_d_size;
      m_d_source[TL_RS*i +: TL_RS] = s_d_source[TL_RS-1:0];
      m_d_denied[i]                = s_d_denied;
      m_d_data[DW*i +: DW]         = s_d_data;
      m_d_corrupt[i]               = s_d_corrupt;
      m_d_valid[i]                 = s_d_valid & (d_idx == IDXW'(i));
`ifdef CLINT_ARB_DENY_BURST_EN
      if (lr_valid && lr_idx == IDXW'(i)) begin
        m_d_opcode[OPW*i +: OPW]     = lr_ack_op;
        m_d_param[DPRMW*i +: DPRMW]  = '0;
        m_d_size[SZW*i +: SZW]       = lr_size;
        m_d_source[TL_RS*i +: TL_RS] = lr_src;
        m_d_denied[i]                = 1'b1;
        m_d_data[DW*i +: DW]         = '0;
        m_d_corrupt[i]               = (lr_ack_op == TL_ACCESS_ACK_DATA);
        m_d_valid[i]                 = 1'b1;
      end
`endif
    end
    if (d_legal) s_d_ready = m_d_ready[d_idx];
`ifdef CLINT_ARB_DENY_BURST_EN
    if (lr_valid && d_idx == lr_idx) s_d_ready = 1'b0;
`endif
  end

endmodule
